traffic_phase_controller: RTL and testbench
===========================================

Name: traffic_phase_controller

Overview:
- Phase-sequencing FSM that drives the downstream saturation counter and uses the counter's count output to time each light phase.
- Sequences the north-south and east-west lamps through green, yellow and all-red phases.
- Inserts a pedestrian walk phase when a request is pending, and forces all-red while the emergency override is asserted.
- Outputs drive the lamp decoders. The cnt_* outputs connect one-to-one to the counter's control inputs.

Parameters:
- COUNT_SIZE, 5, width of the counter data path.
- T_GREEN, 20, green dwell in cycles.
- T_YELLOW, 4, yellow dwell in cycles.
- T_ALLRED, 2, all-red dwell in cycles.
- T_WALK, 10, pedestrian walk dwell in cycles.
- Every T_* value must satisfy 1 ≤ T ≤ 2^COUNT_SIZE.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ped_req  input  1  pedestrian button; level or pulse, sampled every cycle.
- emerg  input  1  emergency override; level-sensitive.
- cnt_out  input  COUNT_SIZE  current count from the saturation counter.
- cnt_load  output  1  load the counter with cnt_in.
- cnt_in  output  COUNT_SIZE  load value: next phase dwell minus 1.
- cnt_up  output  1  always 0.
- cnt_down  output  1  decrement request.
- cnt_loadMax  output  1  load the counter's max register.
- cnt_maxIn  output  COUNT_SIZE  max value, all ones.
- ns_light  output  2  north-south lamp: 00 red, 01 green, 10 yellow.
- ew_light  output  2  east-west lamp, same encoding as ns_light.
- walk  output  1  pedestrian walk lamp.
- phase  output  3  current state encoding, for debug.

Behaviour:
- States and encodings: INIT=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_A=3, EW_GREEN=4, EW_YELLOW=5, ALLRED_B=6, PED_WALK=7. EMERG is a separate 1-bit flag; when the flag is set, phase reads 0.
- Reset (rst=0, asynchronous): state=INIT, ped_pending=0, emerg_flag=0. Lamps red (00), walk=0.
- Reset output values: cnt_load=1, cnt_loadMax=1, cnt_in=T_ALLRED-1, cnt_down=0, cnt_up=0, cnt_maxIn=all ones.
- Reset asserted mid-phase: immediate return to INIT, pending request lost.
- INIT: one cycle only. Asserts cnt_loadMax=1 and cnt_load=1 with cnt_in=T_GREEN-1, then moves to NS_GREEN.
- Advance condition: not in INIT, emerg_flag=0, and cnt_out==0.
- On advance, in the same cycle:
  - cnt_load=1 and cnt_down=0;
  - cnt_in = (next state dwell) - 1, truncated to COUNT_SIZE bits;
  - state updates at the edge.
- Resulting timing: the counter holds T-1 in the first cycle of the new state, so each state lasts exactly T cycles.
- When not advancing in a timed state: cnt_down=1 and cnt_load=0. The counter saturates at 0 and never wraps.
- Transitions:
  - NS_GREEN → NS_YELLOW → ALLRED_A → EW_GREEN → EW_YELLOW → ALLRED_B.
  - ALLRED_B → PED_WALK if ped_pending=1, otherwise → NS_GREEN.
  - PED_WALK → NS_GREEN.
- Lamps by state:
  - NS_GREEN: ns=01. NS_YELLOW: ns=10.
  - EW_GREEN: ew=01. EW_YELLOW: ew=10.
  - Every other lamp in every state is 00.
  - walk=1 only in PED_WALK.
- Output timing: lamps and walk are registered-state decodes (Moore), so they change the cycle after the advance edge.
- ped_pending:
  - set when ped_req=1 in any cycle;
  - cleared on the edge entering PED_WALK;
  - ped_req=1 on that same edge is ignored, so each walk needs a fresh request;
  - ped_req during PED_WALK sets pending for the next cycle.
- Emergency override:
  - emerg=1 in any cycle sets emerg_flag at the next edge. All lamps and walk go to 0 the cycle after. cnt_down=0 and cnt_load=0 while the flag is set, so the count is frozen.
  - When emerg returns to 0 with the flag set: assert cnt_load with cnt_in=T_ALLRED-1, clear the flag, and set state=ALLRED_B. ped_pending is preserved.
  - emerg coinciding with an advance: emerg wins. No load, and the state is unchanged under the flag.
- Dwell of 1: cnt_in=0, so the advance occurs in the first cycle of the state.

Test Plan:
- Reset release with defaults, no requests, no emerg → sequence dwells NS_GREEN 20 cycles, NS_YELLOW 4, ALLRED_A 2, EW_GREEN 20, EW_YELLOW 4, ALLRED_B 2, then NS_GREEN again; period 52 cycles; the cycle after INIT shows cnt_out=19.
- One-cycle ped_req pulse during EW_GREEN → PED_WALK after ALLRED_B with walk=1 for 10 cycles, then NS_GREEN; the next cycle without a request skips PED_WALK.
- emerg asserted for 7 cycles at cycle 5 of NS_GREEN → all lamps 00 and cnt_out frozen; on release, ALLRED_B for 2 cycles then NS_GREEN for a full 20 cycles.
- T_YELLOW=1, T_ALLRED=1 → each of those states lasts exactly one cycle, and cnt_in=0 is observed on their entry loads.
- rst pulled low mid-EW_YELLOW with ped_pending=1 → outputs take reset values immediately, without waiting for clk; after release INIT is followed by NS_GREEN, and PED_WALK does not occur on the next ALLRED_B.
- Across every test → cnt_up=0 always; cnt_load and cnt_down are never both 1; the counter is never decremented while cnt_out=0.

Source files
------------

// File: rtl/traffic_phase_controller_if.sv
// Control/status bus between the phase controller and its downstream saturation counter.
interface traffic_phase_controller_if #(
    parameter int unsigned COUNT_SIZE = 5
) ();
    logic                  cnt_load;
    logic [COUNT_SIZE-1:0] cnt_in;
    logic                  cnt_up;
    logic                  cnt_down;
    logic                  cnt_loadMax;
    logic [COUNT_SIZE-1:0] cnt_maxIn;
    logic [COUNT_SIZE-1:0] cnt_out;

    modport master (
        output cnt_load, cnt_in, cnt_up, cnt_down, cnt_loadMax, cnt_maxIn,
        input  cnt_out
    );

    modport slave (
        input  cnt_load, cnt_in, cnt_up, cnt_down, cnt_loadMax, cnt_maxIn,
        output cnt_out
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// Traffic light phase sequencer; times each phase by loading and draining an external
// saturation counter, with a pedestrian walk insert and an emergency all-red override.
module traffic_phase_controller #(
    parameter int unsigned COUNT_SIZE = 5,
    parameter int unsigned T_GREEN    = 20,
    parameter int unsigned T_YELLOW   = 4,
    parameter int unsigned T_ALLRED   = 2,
    parameter int unsigned T_WALK     = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ped_req,
    input  logic                              emerg,
    traffic_phase_controller_if.master        cnt,
    output logic [1:0]                        ns_light,
    output logic [1:0]                        ew_light,
    output logic                              walk,
    output logic [2:0]                        phase
);
    localparam int unsigned W = COUNT_SIZE;

    localparam logic [W-1:0] GREEN_M1  = W'(T_GREEN - 1);
    localparam logic [W-1:0] YELLOW_M1 = W'(T_YELLOW - 1);
    localparam logic [W-1:0] ALLRED_M1 = W'(T_ALLRED - 1);
    localparam logic [W-1:0] WALK_M1   = W'(T_WALK - 1);

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_A  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        ALLRED_B  = 3'd6,
        PED_WALK  = 3'd7
    } state_t;

    state_t state;
    state_t state_next;
    logic   ped_pending;
    logic   ped_pending_next;
    logic   emerg_flag;
    logic   emerg_flag_next;

    // Counter preload for a state: its dwell minus one, so the state lasts exactly T cycles.
    function automatic logic [W-1:0] dwell_m1(input state_t s);
        case (s)
            NS_YELLOW, EW_YELLOW: dwell_m1 = YELLOW_M1;
            ALLRED_A, ALLRED_B:   dwell_m1 = ALLRED_M1;
            PED_WALK:             dwell_m1 = WALK_M1;
            default:              dwell_m1 = GREEN_M1;
        endcase
    endfunction

    function automatic state_t successor(input state_t s, input logic pend);
        case (s)
            NS_GREEN:  successor = NS_YELLOW;
            NS_YELLOW: successor = ALLRED_A;
            ALLRED_A:  successor = EW_GREEN;
            EW_GREEN:  successor = EW_YELLOW;
            EW_YELLOW: successor = ALLRED_B;
            ALLRED_B:  successor = pend ? PED_WALK : NS_GREEN;
            default:   successor = NS_GREEN;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= INIT;
            ped_pending <= 1'b0;
            emerg_flag  <= 1'b0;
        end else begin
            state       <= state_next;
            ped_pending <= ped_pending_next;
            emerg_flag  <= emerg_flag_next;
        end
    end

    always_comb begin
        state_next       = state;
        ped_pending_next = ped_pending | ped_req;
        emerg_flag_next  = emerg_flag | emerg;
        cnt.cnt_load     = 1'b0;
        cnt.cnt_down     = 1'b0;
        cnt.cnt_up       = 1'b0;
        cnt.cnt_loadMax  = (state == INIT);
        cnt.cnt_maxIn    = '1;
        cnt.cnt_in       = dwell_m1(successor(state, ped_pending));
        ns_light         = LAMP_RED;
        ew_light         = LAMP_RED;
        walk             = 1'b0;
        phase            = 3'd0;

        if (state == INIT) begin
            cnt.cnt_load = 1'b1;
            cnt.cnt_in   = GREEN_M1;
            state_next   = NS_GREEN;
        end else if (emerg_flag) begin
            // Override release resumes through a full all-red before the next green.
            if (!emerg) begin
                cnt.cnt_load    = 1'b1;
                cnt.cnt_in      = ALLRED_M1;
                state_next      = ALLRED_B;
                emerg_flag_next = 1'b0;
            end
        end else if (cnt.cnt_out == '0) begin
            // A fresh override holds the expired phase instead of advancing it.
            if (!emerg) begin
                state_next   = successor(state, ped_pending);
                cnt.cnt_load = 1'b1;
                cnt.cnt_in   = dwell_m1(state_next);
                if (state_next == PED_WALK) begin
                    ped_pending_next = 1'b0;
                end
            end
        end else begin
            cnt.cnt_down = 1'b1;
        end

        if (!rst) begin
            cnt.cnt_in = ALLRED_M1;
        end

        if (!emerg_flag) begin
            phase = 3'(state);
            case (state)
                NS_GREEN:  ns_light = LAMP_GREEN;
                NS_YELLOW: ns_light = LAMP_YELLOW;
                EW_GREEN:  ew_light = LAMP_GREEN;
                EW_YELLOW: ew_light = LAMP_YELLOW;
                PED_WALK:  walk     = 1'b1;
                default:   ;
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: two instances (default dwells and 1-cycle yellow/all-red),
// each driving a saturation counter stand-in and checked every cycle against a phase-schedule model.
module tb_traffic_phase_controller;
    localparam int unsigned CS = 5;
    localparam int T_G  = 20;
    localparam int T_W  = 10;
    localparam int T_Y0 = 4;
    localparam int T_A0 = 2;
    localparam int T_Y1 = 1;
    localparam int T_A1 = 1;

    // Schedule model: current phase number, cycles left in it, pending walk, override active.
    typedef struct packed {
        int ph;
        int left;
        bit pend;
        bit flag;
    } mstate_t;

    logic clk = 1'b0;
    logic rst;
    logic ped_req;
    logic emerg;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_on   = 1'b0;

    always #5 clk = ~clk;

    traffic_phase_controller_if #(.COUNT_SIZE(CS)) bus0 ();
    traffic_phase_controller_if #(.COUNT_SIZE(CS)) bus1 ();

    logic [1:0]    ns_w   [2];
    logic [1:0]    ew_w   [2];
    logic          walk_w [2];
    logic [2:0]    ph_w   [2];
    logic          load_w [2];
    logic          down_w [2];
    logic          up_w   [2];
    logic          lmax_w [2];
    logic [CS-1:0] cin_w  [2];
    logic [CS-1:0] cmax_w [2];
    logic [CS-1:0] cq     [2];
    logic [CS-1:0] cmaxr  [2];

    traffic_phase_controller #(.COUNT_SIZE(CS)) dut0 (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg), .cnt(bus0),
        .ns_light(ns_w[0]), .ew_light(ew_w[0]), .walk(walk_w[0]), .phase(ph_w[0])
    );

    traffic_phase_controller #(.COUNT_SIZE(CS), .T_YELLOW(T_Y1), .T_ALLRED(T_A1)) dut1 (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg), .cnt(bus1),
        .ns_light(ns_w[1]), .ew_light(ew_w[1]), .walk(walk_w[1]), .phase(ph_w[1])
    );

    assign load_w[0] = bus0.cnt_load;
    assign down_w[0] = bus0.cnt_down;
    assign up_w[0]   = bus0.cnt_up;
    assign lmax_w[0] = bus0.cnt_loadMax;
    assign cin_w[0]  = bus0.cnt_in;
    assign cmax_w[0] = bus0.cnt_maxIn;
    assign bus0.cnt_out = cq[0];
    assign load_w[1] = bus1.cnt_load;
    assign down_w[1] = bus1.cnt_down;
    assign up_w[1]   = bus1.cnt_up;
    assign lmax_w[1] = bus1.cnt_loadMax;
    assign cin_w[1]  = bus1.cnt_in;
    assign cmax_w[1] = bus1.cnt_maxIn;
    assign bus1.cnt_out = cq[1];

    // Saturating counter stand-in for the downstream block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                cq[i]    <= '0;
                cmaxr[i] <= '1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (lmax_w[i]) cmaxr[i] <= cmax_w[i];
                if (load_w[i]) cq[i] <= cin_w[i];
                else if (up_w[i] && cq[i] != cmaxr[i]) cq[i] <= cq[i] + 1'b1;
                else if (down_w[i] && cq[i] != '0) cq[i] <= cq[i] - 1'b1;
            end
        end
    end

    function automatic int dwell(input int inst, input int ph);
        case (ph)
            2, 5:    return (inst == 0) ? T_Y0 : T_Y1;
            3, 6:    return (inst == 0) ? T_A0 : T_A1;
            7:       return T_W;
            default: return T_G;
        endcase
    endfunction

    function automatic int succ(input int ph, input bit pend);
        if (ph == 6) return pend ? 7 : 1;
        if (ph == 7) return 1;
        return ph + 1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input int inst, input bit em, input bit pr);
        mstate_t n;
        n = s;
        n.flag = s.flag | em;
        n.pend = s.pend | pr;
        if (s.ph == 0) begin
            n.ph   = 1;
            n.left = dwell(inst, 1);
        end else if (s.flag) begin
            if (!em) begin
                n.flag = 1'b0;
                n.ph   = 6;
                n.left = dwell(inst, 6);
            end
        end else if (em) begin
            if (s.left > 1) n.left = s.left - 1;
        end else if (s.left == 1) begin
            n.ph   = succ(s.ph, s.pend);
            n.left = dwell(inst, n.ph);
            if (n.ph == 7) n.pend = 1'b0;
        end else begin
            n.left = s.left - 1;
        end
        return n;
    endfunction

    mstate_t m [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) m[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) m[i] <= model_next(m[i], i, emerg, ped_req);
        end
    end

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic compare(input int i);
        mstate_t s;
        bit  live;
        int  e_ns, e_ew, e_load, e_down, e_in;
        s    = m[i];
        live = !s.flag;
        e_ns = 0;
        e_ew = 0;
        if (live && s.ph == 1) e_ns = 1;
        if (live && s.ph == 2) e_ns = 2;
        if (live && s.ph == 4) e_ew = 1;
        if (live && s.ph == 5) e_ew = 2;
        e_load = (!rst || s.ph == 0 || (s.flag && !emerg) || (!s.flag && !emerg && s.left == 1)) ? 1 : 0;
        e_down = (rst && s.ph != 0 && !s.flag && s.left > 1) ? 1 : 0;
        check("phase",    i, int'(ph_w[i]),   live ? s.ph : 0);
        check("ns_light", i, int'(ns_w[i]),   e_ns);
        check("ew_light", i, int'(ew_w[i]),   e_ew);
        check("walk",     i, int'(walk_w[i]), (live && s.ph == 7) ? 1 : 0);
        check("cnt_load", i, int'(load_w[i]), e_load);
        check("cnt_down", i, int'(down_w[i]), e_down);
        check("cnt_up",   i, int'(up_w[i]),   0);
        check("cnt_maxIn", i, int'(cmax_w[i]), (1 << CS) - 1);
        check("cnt_loadMax", i, int'(lmax_w[i]), (s.ph == 0) ? 1 : 0);
        if (e_load == 1) begin
            if (!rst)          e_in = dwell(i, 3) - 1;
            else if (s.ph == 0) e_in = T_G - 1;
            else if (s.flag)   e_in = dwell(i, 6) - 1;
            else               e_in = dwell(i, succ(s.ph, s.pend)) - 1;
            check("cnt_in", i, int'(cin_w[i]), e_in);
        end
        if (rst && s.ph != 0) check("cnt_out", i, int'(cq[i]), s.left - 1);
        check("load_and_down", i, (load_w[i] && down_w[i]) ? 1 : 0, 0);
        check("down_at_zero",  i, (down_w[i] && cq[i] == '0) ? 1 : 0, 0);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) compare(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input int inst, input int p, input int len, input string name, output int n);
        n = 0;
        check({name, "_enter"}, inst, int'(ph_w[inst]), p);
        while (int'(ph_w[inst]) == p && n < 200) begin
            tick();
            n++;
        end
        check({name, "_len"}, inst, n, len);
    endtask

    task automatic wait_phase(input int inst, input int p, input string name);
        int n;
        n = 0;
        while (int'(ph_w[inst]) != p && n < 300) begin
            tick();
            n++;
        end
        check(name, inst, int'(ph_w[inst]), p);
    endtask

    task automatic full_cycle(input string tag, output int total);
        int n;
        total = 0;
        expect_run(0, 1, 20, {tag, "_ns_green"},  n); total += n;
        expect_run(0, 2, 4,  {tag, "_ns_yellow"}, n); total += n;
        expect_run(0, 3, 2,  {tag, "_allred_a"},  n); total += n;
        expect_run(0, 4, 20, {tag, "_ew_green"},  n); total += n;
        expect_run(0, 5, 4,  {tag, "_ew_yellow"}, n); total += n;
        expect_run(0, 6, 2,  {tag, "_allred_b"},  n); total += n;
    endtask

    initial begin
        int n;
        int total;
        rst     = 1'b0;
        ped_req = 1'b0;
        emerg   = 1'b0;
        @(posedge clk);
        #1;
        cmp_on = 1'b1;
        tick();

        check("rst_load",    0, int'(load_w[0]), 1);
        check("rst_loadMax", 0, int'(lmax_w[0]), 1);
        check("rst_cin",     0, int'(cin_w[0]),  1);
        check("rst_cin",     1, int'(cin_w[1]),  0);
        check("rst_down",    0, int'(down_w[0]), 0);
        check("rst_phase",   0, int'(ph_w[0]),   0);
        check("rst_walk",    0, int'(walk_w[0]), 0);

        rst = 1'b1;
        #1;
        check("init_phase", 0, int'(ph_w[0]),  0);
        check("init_cin",   0, int'(cin_w[0]), 19);
        tick();
        check("first_cnt_out", 0, int'(cq[0]),   19);
        check("first_phase",   0, int'(ph_w[0]), 1);
        check("first_ns",      0, int'(ns_w[0]), 1);
        full_cycle("p1", total);
        check("period", 0, total, 52);
        check("wrap_to_ns_green", 0, int'(ph_w[0]), 1);

        // Short-dwell instance: yellow and all-red last one cycle each, entered with cnt_in=0.
        n = 0;
        while (int'(ph_w[1]) != 2 && n < 100) begin
            if (ph_w[1] == 3'd1 && load_w[1]) check("d1_yellow_entry_cin", 1, int'(cin_w[1]), 0);
            tick();
            n++;
        end
        check("d1_reach_yellow", 1, int'(ph_w[1]), 2);
        check("d1_allred_entry_load", 1, int'(load_w[1]), 1);
        check("d1_allred_entry_cin",  1, int'(cin_w[1]),  0);
        expect_run(1, 2, 1,  "d1_ns_yellow", n);
        expect_run(1, 3, 1,  "d1_allred_a",  n);
        expect_run(1, 4, 20, "d1_ew_green",  n);
        expect_run(1, 5, 1,  "d1_ew_yellow", n);
        expect_run(1, 6, 1,  "d1_allred_b",  n);
        check("d1_wrap", 1, int'(ph_w[1]), 1);

        // One-cycle pedestrian pulse during EW_GREEN.
        wait_phase(0, 4, "ped_reach_ew_green");
        repeat (3) tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        wait_phase(0, 5, "ped_reach_ew_yellow");
        expect_run(0, 5, 4, "ped_ew_yellow", n);
        expect_run(0, 6, 2, "ped_allred_b",  n);
        check("walk_on", 0, int'(walk_w[0]), 1);
        expect_run(0, 7, 10, "ped_walk", n);
        check("walk_off", 0, int'(walk_w[0]), 0);
        full_cycle("p2", total);
        check("no_second_walk", 0, int'(ph_w[0]), 1);

        // Emergency for 7 cycles starting at cycle 5 of NS_GREEN.
        repeat (4) tick();
        check("emerg_start_cnt", 0, int'(cq[0]), 15);
        emerg = 1'b1;
        repeat (6) begin
            tick();
            check("emerg_phase", 0, int'(ph_w[0]), 0);
            check("emerg_ns",    0, int'(ns_w[0]), 0);
            check("emerg_frozen_cnt", 0, int'(cq[0]), 14);
        end
        tick();
        emerg = 1'b0;
        #1;
        check("emerg_release_load", 0, int'(load_w[0]), 1);
        check("emerg_release_cin",  0, int'(cin_w[0]),  1);
        tick();
        expect_run(0, 6, 2,  "emerg_allred_b", n);
        expect_run(0, 1, 20, "emerg_ns_green", n);

        // Asynchronous reset in EW_YELLOW with a walk pending.
        wait_phase(0, 5, "rst_reach_ew_yellow");
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        check("rst_pre_phase", 0, int'(ph_w[0]), 5);
        #2;
        rst = 1'b0;
        #1;
        check("async_phase",   0, int'(ph_w[0]),   0);
        check("async_ew",      0, int'(ew_w[0]),   0);
        check("async_load",    0, int'(load_w[0]), 1);
        check("async_cin",     0, int'(cin_w[0]),  1);
        check("async_loadMax", 0, int'(lmax_w[0]), 1);
        check("async_down",    0, int'(down_w[0]), 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("reinit_phase", 0, int'(ph_w[0]),  0);
        check("reinit_cin",   0, int'(cin_w[0]), 19);
        tick();
        full_cycle("p3", total);
        check("no_walk_after_reset", 0, int'(ph_w[0]), 1);

        repeat (3) tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
